// File: rtl/iterative_alu.sv
// rtl/iterative_alu.sv - EX-stage ALU: single-cycle add/sub/and/or, iterative shift-add mul
// Registered result with a one-cycle done pulse; stall_o freezes the pipeline while mul iterates.
module iterative_alu #(
  parameter int WIDTH    = 32,
  parameter int MUL_STEP = 1
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             valid_i,
  input  logic             flush_i,
  input  logic [2:0]       ALUCtrl_i,
  input  logic [WIDTH-1:0] data1_i,
  input  logic [WIDTH-1:0] data2_i,
  output logic [WIDTH-1:0] data_o,
  output logic             zero_o,
  output logic             done_o,
  output logic             stall_o
);

  localparam int N  = WIDTH / MUL_STEP;
  localparam int CW = $clog2(N) + 1;
  localparam logic [CW-1:0] LAST_ITER = CW'(N - 1);

  localparam logic [2:0] OP_AND = 3'b000;
  localparam logic [2:0] OP_OR  = 3'b001;
  localparam logic [2:0] OP_ADD = 3'b010;
  localparam logic [2:0] OP_SUB = 3'b110;
  localparam logic [2:0] OP_MUL = 3'b101;

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DONE} state_t;

  state_t           state_q;
  logic [WIDTH-1:0] mcand_q;
  logic [WIDTH-1:0] mplier_q;
  logic [WIDTH-1:0] acc_q;
  logic [WIDTH-1:0] data_q;
  logic [CW-1:0]    cnt_q;
  logic             zero_q;
  logic             done_q;

  logic [WIDTH-1:0] fast_d;
  logic [WIDTH-1:0] partial_d;
  logic [WIDTH-1:0] acc_d;
  logic             is_mul;

  assign is_mul = (ALUCtrl_i == OP_MUL);

  always_comb begin
    fast_d = '0;
    case (ALUCtrl_i)
      OP_ADD:  fast_d = data1_i + data2_i;
      OP_SUB:  fast_d = data1_i - data2_i;
      OP_AND:  fast_d = data1_i & data2_i;
      OP_OR:   fast_d = data1_i | data2_i;
      default: fast_d = '0;
    endcase
  end

  // Only the low WIDTH product bits are kept, so operand signedness never matters.
  always_comb begin
    partial_d = '0;
    for (int j = 0; j < MUL_STEP; j++) begin
      if (mplier_q[j]) partial_d = partial_d + (mcand_q << j);
    end
    acc_d = acc_q + partial_d;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= S_IDLE;
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      data_q   <= '0;
      cnt_q    <= '0;
      zero_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (valid_i && !flush_i) begin
            if (is_mul) begin
              mcand_q  <= data1_i;
              mplier_q <= data2_i;
              acc_q    <= '0;
              cnt_q    <= '0;
              state_q  <= S_MUL;
            end else begin
              data_q <= fast_d;
              zero_q <= (fast_d == '0);
              done_q <= 1'b1;
            end
          end
        end
        S_MUL: begin
          if (flush_i) begin
            state_q <= S_IDLE;
          end else begin
            acc_q    <= acc_d;
            mcand_q  <= mcand_q << MUL_STEP;
            mplier_q <= mplier_q >> MUL_STEP;
            cnt_q    <= cnt_q + CW'(1);
            if (cnt_q == LAST_ITER) begin
              data_q  <= acc_d;
              zero_q  <= (acc_d == '0);
              done_q  <= 1'b1;
              state_q <= S_DONE;
            end
          end
        end
        S_DONE:  state_q <= S_IDLE;
        default: state_q <= S_IDLE;
      endcase
    end
  end

  // The held mul sits in EX during DONE, so the pipeline is released there without re-accepting it.
  assign stall_o = !rst_i && ((state_q == S_MUL) ||
                              ((state_q == S_IDLE) && valid_i && !flush_i && is_mul));
  assign data_o  = data_q;
  assign zero_o  = zero_q;
  assign done_o  = done_q;

endmodule
